// File: rtl/sysad_responder.sv
// SysAD external agent: accepts VR4300 block reads/writes, buffers one block, forwards irq.
// Optional backend ack watchdog enabled by defining SYSAD_TIMEOUT_EN.
module sysad_responder #(
  parameter int MAX_WORDS = 8,
  parameter int TIMEOUT   = 255
) (
  input  logic        sysclk,
  input  logic        reset,
  input  logic        p_valid_l,
  input  logic [31:0] sys_ad_in,
  input  logic [4:0]  sys_cmd_in,
  output logic [31:0] sys_ad_out,
  output logic [4:0]  sys_cmd_out,
  output logic        sys_ad_oe,
  output logic        e_valid_l,
  output logic        e_ok_l,
  input  logic        irq,
  output logic        int_l,
  output logic        be_req,
  output logic        be_write,
  output logic [31:0] be_addr,
  output logic [31:0] be_wdata,
  input  logic        be_ack,
  input  logic [31:0] be_rdata,
  output logic        err
);

  typedef enum logic [2:0] {
    IDLE, WCAP, WDRAIN, RFETCH, RTURN, RDRIVE, RREL
  } state_t;

  localparam logic [4:0] CMD_LAST = 5'b10000;
  localparam logic [4:0] CMD_MORE = 5'b11000;

  state_t      state, state_n;
  logic [3:0]  cnt, cnt_n, total, total_n, size;
  logic [26:0] blk_hi;
  logic [2:0]  blk_lo, start, mask;
  logic [31:0] buffer [MAX_WORDS];

  logic        accept, data_cycle, ack, done, store, tmo_fire, unused_ok;
  logic [3:0]  req_size;
  logic [2:0]  req_mask, a_lo, a_start, a_mask, a_off;
  logic [26:0] a_hi;
  logic [31:0] rdata_eff;

  assign accept     = (state == IDLE) && !p_valid_l && !sys_cmd_in[4];
  assign data_cycle = !p_valid_l && sys_cmd_in[4];
  assign ack        = be_ack && be_req;
  assign done       = ack || tmo_fire;
  assign rdata_eff  = ack ? be_rdata : 32'hDEAD_BEEF;

  always_comb begin
    req_size = 4'd1 << sys_cmd_in[1:0];
    if (int'(req_size) > MAX_WORDS) req_size = 4'(MAX_WORDS);
    req_mask = req_size[2:0] - 3'd1;
  end

  // The word address for the first beat must use the request being accepted this cycle.
  assign a_hi    = accept ? sys_ad_in[31:5] : blk_hi;
  assign a_lo    = accept ? (sys_ad_in[4:2] & ~req_mask) : blk_lo;
  assign a_start = accept ? (sys_ad_in[4:2] & req_mask) : start;
  assign a_mask  = accept ? req_mask : mask;
  assign a_off   = a_lo | ((a_start + cnt_n[2:0]) & a_mask);

  always_comb begin
    // NOTE: every variable gets a default first so no path through the case infers a latch.
    state_n = state;
    cnt_n   = cnt;
    total_n = total;
    store   = 1'b0;
    case (state)
      IDLE: if (accept) begin
        state_n = sys_cmd_in[3] ? WCAP : RFETCH;
        cnt_n   = '0;
      end
      WCAP: if (data_cycle) begin
        store = 1'b1;
        if (!sys_cmd_in[3] || (cnt + 4'd1 == size)) begin
          state_n = WDRAIN;
          total_n = cnt + 4'd1;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + 4'd1;
        end
      end
      WDRAIN: if (done) begin
        if (cnt + 4'd1 == total) state_n = IDLE;
        else                     cnt_n   = cnt + 4'd1;
      end
      RFETCH: if (done) begin
        if (cnt + 4'd1 == size) begin
          state_n = RTURN;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + 4'd1;
        end
      end
      RTURN: state_n = RDRIVE;
      RDRIVE: begin
        if (cnt + 4'd1 == size) begin
          state_n = RREL;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + 4'd1;
        end
      end
      RREL:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge sysclk) begin
    // NOTE: non-blocking assignments so every register updates together at the edge.
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      total       <= '0;
      size        <= 4'd1;
      blk_hi      <= '0;
      blk_lo      <= '0;
      start       <= '0;
      mask        <= '0;
      sys_ad_out  <= '0;
      sys_cmd_out <= '0;
      sys_ad_oe   <= 1'b0;
      e_valid_l   <= 1'b1;
      e_ok_l      <= 1'b1;
      int_l       <= 1'b1;
      be_req      <= 1'b0;
      be_write    <= 1'b0;
      be_addr     <= '0;
      be_wdata    <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      total <= total_n;
      if (accept) begin
        size   <= req_size;
        blk_hi <= sys_ad_in[31:5];
        blk_lo <= sys_ad_in[4:2] & ~req_mask;
        start  <= sys_ad_in[4:2] & req_mask;
        mask   <= req_mask;
      end
      // Outputs are registered from the next state so they line up with it.
      e_ok_l    <= (state_n != IDLE);
      int_l     <= ~irq;
      be_req    <= (state_n == WDRAIN) || (state_n == RFETCH);
      be_write  <= (state_n == WDRAIN);
      be_addr   <= {a_hi, a_off, 2'b00};
      be_wdata  <= (store && (cnt == cnt_n)) ? sys_ad_in : buffer[cnt_n[2:0]];
      sys_ad_oe <= (state_n == RTURN) || (state_n == RDRIVE);
      e_valid_l <= (state_n != RDRIVE);
      if (state_n == RDRIVE) begin
        sys_ad_out  <= buffer[cnt_n[2:0]];
        sys_cmd_out <= (cnt_n + 4'd1 == size) ? CMD_LAST : CMD_MORE;
      end else begin
        sys_ad_out  <= '0;
        sys_cmd_out <= '0;
      end
    end
  end

  // NOTE: the buffer has no reset; state and cnt reset make stale contents unreachable.
  always_ff @(posedge sysclk) begin
    if (store)                       buffer[cnt[2:0]] <= sys_ad_in;
    else if (state == RFETCH && done) buffer[cnt[2:0]] <= rdata_eff;
  end

`ifdef SYSAD_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] tmo_cnt;

  assign tmo_fire  = be_req && !be_ack && (tmo_cnt == TW'(TIMEOUT - 1));
  assign unused_ok = &{1'b0, sys_cmd_in[2]};

  always_ff @(posedge sysclk) begin
    if (reset || !be_req || done) tmo_cnt <= '0;
    else                          tmo_cnt <= tmo_cnt + 1'b1;
  end

  always_ff @(posedge sysclk) begin
    if (reset)         err <= 1'b0;
    else if (tmo_fire) err <= 1'b1;
  end
`else
  assign tmo_fire  = 1'b0;
  assign err       = 1'b0;
  assign unused_ok = &{1'b0, sys_cmd_in[2], TIMEOUT != 0};
`endif

endmodule

// File: tb/tb_sysad_responder.sv
// Directed bench for sysad_responder: scoreboard queues filled at stimulus, drained by negedge monitors.
module tb_sysad_responder;

  logic        sysclk = 1'b0;
  logic        reset = 1'b1;
  logic        p_valid_l = 1'b1;
  logic [31:0] sys_ad_in = '0;
  logic [4:0]  sys_cmd_in = '0;
  logic [31:0] sys_ad_out;
  logic [4:0]  sys_cmd_out;
  logic        sys_ad_oe, e_valid_l, e_ok_l, int_l, be_req, be_write, be_ack, err;
  logic        irq = 1'b0;
  logic [31:0] be_addr, be_wdata, be_rdata;

  int   ack_mode = 0;  // 0 zero-wait, 1 every other cycle, 2 never
  logic ack_force = 1'b0;
  logic phase = 1'b0;

  always #5 sysclk = ~sysclk;
  always @(posedge sysclk) phase <= ~phase;

  assign be_ack   = (be_req && (ack_mode == 0 || (ack_mode == 1 && phase))) || ack_force;
  assign be_rdata = be_addr ^ 32'hA5A5_A5A5;

  sysad_responder #(.MAX_WORDS(8), .TIMEOUT(16)) dut (
    .sysclk(sysclk), .reset(reset), .p_valid_l(p_valid_l), .sys_ad_in(sys_ad_in),
    .sys_cmd_in(sys_cmd_in), .sys_ad_out(sys_ad_out), .sys_cmd_out(sys_cmd_out),
    .sys_ad_oe(sys_ad_oe), .e_valid_l(e_valid_l), .e_ok_l(e_ok_l), .irq(irq),
    .int_l(int_l), .be_req(be_req), .be_write(be_write), .be_addr(be_addr),
    .be_wdata(be_wdata), .be_ack(be_ack), .be_rdata(be_rdata), .err(err)
  );

  typedef struct packed { logic [31:0] addr; logic [31:0] data; } wr_t;
  typedef struct packed { logic [31:0] data; logic [4:0] cmd; } rd_t;

  wr_t         exp_w[$];
  logic [31:0] exp_f[$];
  rd_t         exp_r[$];
  wr_t         mon_w;
  logic [31:0] mon_f;
  rd_t         mon_r;
  int          n_checks = 0;
  int          n_fail = 0;
  int          w_seen = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  always @(negedge sysclk) begin
    if (be_req === 1'b1 && be_ack === 1'b1) begin
      if (be_write) begin
        w_seen++;
        check("wr_expected", 32'(exp_w.size() > 0), 32'd1);
        if (exp_w.size() > 0) begin
          mon_w = exp_w.pop_front();
          check("wr_addr", be_addr, mon_w.addr);
          check("wr_data", be_wdata, mon_w.data);
        end
      end else begin
        check("fetch_expected", 32'(exp_f.size() > 0), 32'd1);
        if (exp_f.size() > 0) begin
          mon_f = exp_f.pop_front();
          check("fetch_addr", be_addr, mon_f);
        end
      end
    end
    if (e_valid_l === 1'b0) begin
      check("rd_expected", 32'(exp_r.size() > 0), 32'd1);
      if (exp_r.size() > 0) begin
        mon_r = exp_r.pop_front();
        check("rd_data", sys_ad_out, mon_r.data);
        check("rd_cmd", 32'(sys_cmd_out), 32'(mon_r.cmd));
      end
    end
  end

  task automatic tick();
    @(posedge sysclk);
    #1;
  endtask

  task automatic bus(input logic pv, input logic [31:0] ad, input logic [4:0] cmd);
    p_valid_l  = pv;
    sys_ad_in  = ad;
    sys_cmd_in = cmd;
    tick();
  endtask

  task automatic idle_bus();
    p_valid_l  = 1'b1;
    sys_ad_in  = '0;
    sys_cmd_in = '0;
  endtask

  function automatic int nwords(input logic [1:0] code);
    int n;
    n = 1 << code;
    return (n > 8) ? 8 : n;
  endfunction

  function automatic logic [31:0] word_addr(input logic [31:0] addr, input int n, input int i);
    logic [31:0] base;
    int          off;
    base = addr & ~(32'(4 * n) - 32'd1);
    off  = ((int'(addr[4:2]) + i) % n) * 4;
    return base + 32'(off);
  endfunction

  task automatic do_write(input logic [31:0] addr, input logic [1:0] code, input int sent,
                          input bit last_flag, input int gap_a, input int gap_b);
    int          n, exp_n, w0, k;
    bit          ok_low;
    logic [31:0] d [8];
    n     = nwords(code);
    exp_n = (sent < n) ? sent : n;
    for (int i = 0; i < sent; i++) d[i] = $urandom;
    for (int i = 0; i < exp_n; i++) exp_w.push_back('{addr: word_addr(addr, n, i), data: d[i]});
    w0     = w_seen;
    ok_low = 1'b0;
    bus(1'b0, addr, {3'b010, code});
    check("wr_ok_rise", 32'(e_ok_l), 32'd1);
    for (int i = 0; i < sent; i++) begin
      bus(1'b0, d[i], (last_flag && i == sent - 1) ? 5'b10000 : 5'b11000);
      ok_low |= (e_ok_l !== 1'b1);
      if (i == gap_a || i == gap_b) begin
        idle_bus();
        tick();
        ok_low |= (e_ok_l !== 1'b1);
      end
    end
    idle_bus();
    k = 0;
    while (e_ok_l !== 1'b0 && k < 100) begin
      tick();
      k++;
    end
    check("wr_ok_low", 32'(e_ok_l), 32'd0);
    check("wr_ok_high_during", 32'(ok_low), 32'd0);
    check("wr_count", 32'(w_seen - w0), 32'(exp_n));
    check("wr_queue_empty", 32'(exp_w.size()), 32'd0);
  endtask

  task automatic do_read(input logic [31:0] addr, input logic [1:0] code, input int exp_lat,
                         input bit intrude, input bit tmo);
    int          n, lat;
    logic        prev_oe;
    logic [31:0] a;
    n = nwords(code);
    for (int i = 0; i < n; i++) begin
      a = word_addr(addr, n, i);
      if (!tmo) exp_f.push_back(a);
      exp_r.push_back('{data: tmo ? 32'hDEAD_BEEF : (a ^ 32'hA5A5_A5A5),
                        cmd: (i == n - 1) ? 5'b10000 : 5'b11000});
    end
    bus(1'b0, addr, {3'b000, code});
    check("rd_ok_rise", 32'(e_ok_l), 32'd1);
    lat = 1;
    if (intrude) begin
      bus(1'b0, 32'h0400_0F00, 5'b01000);
      lat++;
    end
    idle_bus();
    prev_oe = 1'b0;
    while (e_valid_l !== 1'b0 && lat < 300) begin
      prev_oe = sys_ad_oe;
      tick();
      lat++;
    end
    if (exp_lat > 0) check("rd_latency", 32'(lat), 32'(exp_lat));
    check("rd_turn_oe", 32'(prev_oe), 32'd1);
    for (int i = 0; i < n; i++) begin
      check("rd_drive_oe", 32'({sys_ad_oe, e_valid_l}), 32'd2);
      tick();
    end
    check("rd_release", 32'({sys_ad_oe, e_valid_l}), 32'd1);
    tick();
    check("rd_idle_ok", 32'(e_ok_l), 32'd0);
    check("rd_queue_empty", 32'(exp_r.size() + exp_f.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "bench did not finish");
  end

  initial begin
    int k, w0;
    tick();
    tick();
    check("rst_e_valid_l", 32'(e_valid_l), 32'd1);
    check("rst_e_ok_l", 32'(e_ok_l), 32'd1);
    check("rst_oe", 32'(sys_ad_oe), 32'd0);
    check("rst_ad_out", sys_ad_out, 32'd0);
    check("rst_cmd_out", 32'(sys_cmd_out), 32'd0);
    check("rst_be_req", 32'(be_req), 32'd0);
    check("rst_int_l", 32'(int_l), 32'd1);
    check("rst_err", 32'(err), 32'd0);
    reset = 1'b0;
    tick();
    check("post_rst_ok", 32'(e_ok_l), 32'd0);

    // Interrupt forwarding, one cycle of latency
    irq = 1'b1;
    check("irq_not_comb", 32'(int_l), 32'd1);
    tick();
    check("irq_assert", 32'(int_l), 32'd0);
    irq = 1'b0;
    tick();
    check("irq_release", 32'(int_l), 32'd1);

    // Stray ack while idle is ignored
    ack_force = 1'b1;
    tick();
    tick();
    ack_force = 1'b0;
    check("stray_ack_ok", 32'(e_ok_l), 32'd0);
    check("stray_ack_req", 32'(be_req), 32'd0);

    // Single-word write
    exp_w.push_back('{addr: 32'h0400_0010, data: 32'h1234_5678});
    bus(1'b0, 32'h0400_0010, 5'b01000);
    check("sw_ok_rise", 32'(e_ok_l), 32'd1);
    bus(1'b0, 32'h1234_5678, 5'b10000);
    idle_bus();
    check("sw_req", 32'({be_req, be_write}), 32'd3);
    check("sw_addr", be_addr, 32'h0400_0010);
    check("sw_data", be_wdata, 32'h1234_5678);
    tick();
    check("sw_ok_low", 32'(e_ok_l), 32'd0);
    check("sw_req_drop", 32'(be_req), 32'd0);
    check("sw_queue_empty", 32'(exp_w.size()), 32'd0);

    do_read(32'h0400_0008, 2'd2, 6, 1'b0, 1'b0);
    do_read(32'h0400_0014, 2'd0, 3, 1'b0, 1'b0);
    do_write(32'h0400_0128, 2'd3, 8, 1'b1, 1, 4);
    do_write(32'h0400_0200, 2'd3, 3, 1'b1, -1, -1);
    do_write(32'h0400_0024, 2'd1, 2, 1'b0, -1, -1);

    // Slow backend; an address cycle during the fetch must be ignored
    ack_mode = 1;
    w0 = w_seen;
    do_read(32'h0400_031C, 2'd3, -1, 1'b1, 1'b0);
    check("intrude_no_write", 32'(w_seen - w0), 32'd0);
    ack_mode = 0;

    // Reset in the middle of RDRIVE
    for (int i = 0; i < 8; i++) begin
      exp_f.push_back(word_addr(32'h0400_0400, 8, i));
      exp_r.push_back('{data: word_addr(32'h0400_0400, 8, i) ^ 32'hA5A5_A5A5,
                        cmd: (i == 7) ? 5'b10000 : 5'b11000});
    end
    bus(1'b0, 32'h0400_0400, 5'b00011);
    idle_bus();
    k = 0;
    while (e_valid_l !== 1'b0 && k < 100) begin
      tick();
      k++;
    end
    check("mid_drive_reached", 32'(e_valid_l), 32'd0);
    tick();
    tick();
    reset = 1'b1;
    tick();
    check("mid_rst_oe", 32'(sys_ad_oe), 32'd0);
    check("mid_rst_e_valid_l", 32'(e_valid_l), 32'd1);
    check("mid_rst_be_req", 32'(be_req), 32'd0);
    check("mid_rst_ok", 32'(e_ok_l), 32'd1);
    reset = 1'b0;
    tick();
    check("mid_rst_ok_low", 32'(e_ok_l), 32'd0);
    check("mid_rst_no_drive", 32'(e_valid_l), 32'd1);
    check("mid_rst_fetched", 32'(exp_f.size()), 32'd0);
    exp_r.delete();

`ifdef SYSAD_TIMEOUT_EN
    ack_mode = 2;
    do_read(32'h0400_0500, 2'd0, -1, 1'b0, 1'b1);
    check("tmo_err_set", 32'(err), 32'd1);
    for (int i = 0; i < 5; i++) tick();
    check("tmo_err_sticky", 32'(err), 32'd1);
    ack_mode = 0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    check("tmo_err_cleared", 32'(err), 32'd0);
`else
    check("err_tied_low", 32'(err), 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
